// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: instruction fetch with req/ack memory handshake, one-entry skid buffer and IF/ID register.
module fetch_issue_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Jump,
  input  logic [ADDR_WIDTH-1:0] JumpTarget,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  output logic                  InstrReq,
  output logic [ADDR_WIDTH-1:0] InstrAddr,
  input  logic                  InstrAck,
  input  logic [31:0]           InstrData,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [31:0]           IFID_Instruction,
  output logic [ADDR_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  IFID_JFlush,
  output logic [5:0]            OpCode,
  output logic [5:0]            Funct
);
  typedef enum logic [1:0] {START, FETCH, HOLD} state_t;
  state_t state;
  logic discard;
  logic [31:0] skid_data;
  logic [ADDR_WIDTH-1:0] skid_pcp4;
  logic redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] addr_p4;
  assign redirect = BranchTaken | Jump;
  assign target = (BranchTaken ? BranchTarget : JumpTarget) & ~ADDR_WIDTH'(3);
  assign addr_p4 = InstrAddr + ADDR_WIDTH'(4);
  assign OpCode = IFID_Instruction[31:26];
  assign Funct = IFID_Instruction[5:0];
  // HOLD doubles as "skid buffer full"; the buffer is only ever loaded on the way into HOLD
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= START;
      PC <= RESET_PC;
      InstrAddr <= RESET_PC;
      InstrReq <= 1'b0;
      discard <= 1'b0;
      skid_data <= NOP_WORD;
      skid_pcp4 <= '0;
      IFID_Instruction <= NOP_WORD;
      IFID_PCPlus4 <= '0;
      IFID_Valid <= 1'b0;
      IFID_JFlush <= 1'b0;
    end else if (state == START) begin
      state <= FETCH;
      InstrReq <= 1'b1;
      InstrAddr <= PC;
    end else if (redirect) begin
      state <= FETCH;
      PC <= target;
      IFID_Instruction <= NOP_WORD;
      IFID_Valid <= 1'b0;
      IFID_JFlush <= 1'b1;
      // an un-acked request must stay stable; its word is dropped when it lands
      if (InstrReq && !InstrAck) discard <= 1'b1;
      else begin
        discard <= 1'b0;
        InstrReq <= 1'b1;
        InstrAddr <= target;
      end
    end else begin
      IFID_JFlush <= 1'b0;
      if (state == HOLD) begin
        if (!Stall) begin
          state <= FETCH;
          IFID_Instruction <= skid_data;
          IFID_PCPlus4 <= skid_pcp4;
          IFID_Valid <= 1'b1;
          InstrReq <= 1'b1;
        end
      end else if (InstrAck && !discard) begin
        InstrAddr <= addr_p4;
        PC <= PC + ADDR_WIDTH'(4);
        if (Stall) begin
          state <= HOLD;
          skid_data <= InstrData;
          skid_pcp4 <= addr_p4;
          InstrReq <= 1'b0;
        end else begin
          IFID_Instruction <= InstrData;
          IFID_PCPlus4 <= addr_p4;
          IFID_Valid <= 1'b1;
        end
      end else begin
        if (InstrAck) begin
          discard <= 1'b0;
          InstrAddr <= PC;
        end
        if (!Stall) begin
          IFID_Instruction <= NOP_WORD;
          IFID_Valid <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fetch_issue_unit;
  logic Clock = 1'b0;
  logic Reset, Stall, Jump, BranchTaken, InstrAck;
  logic [31:0] JumpTarget, BranchTarget, InstrData;
  logic InstrReq, IFID_Valid, IFID_JFlush;
  logic [31:0] InstrAddr, PC, IFID_Instruction, IFID_PCPlus4;
  logic [5:0] OpCode, Funct;
  int vectors = 0, miscompares = 0;
  int lat = 0, cnt = 0;
  bit rand_lat = 0;
  bit m_started, m_req, m_discard, m_valid, m_jflush;
  logic [31:0] m_addr, m_pc, m_instr, m_pcp4;
  logic [63:0] skid[$];

  always #5 Clock = ~Clock;

  fetch_issue_unit dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .InstrReq(InstrReq),
    .InstrAddr(InstrAddr), .InstrAck(InstrAck), .InstrData(InstrData), .PC(PC),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .IFID_JFlush(IFID_JFlush), .OpCode(OpCode), .Funct(Funct)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0: return 32'h20080005;
      32'h4: return 32'h01095020;
      32'h8: return 32'h8C090010;
      default: return {a[15:0] ^ 16'h5A5A, ~a[31:16]} ^ {a[7:0], 24'h3C1F07};
    endcase
  endfunction

  task automatic m_reset();
    m_started = 0; m_req = 0; m_discard = 0; m_valid = 0; m_jflush = 0;
    m_addr = 0; m_pc = 0; m_instr = 0; m_pcp4 = 0;
    skid.delete();
  endtask

  // Each fetched word is either delivered, parked, or dropped; a redirect kills everything in flight.
  task automatic m_update(input bit ack, input logic [31:0] data, input bit s, input bit j,
                          input logic [31:0] jt, input bit b, input logic [31:0] bt);
    logic [31:0] t;
    t = (b ? bt : jt) & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1; m_req = 1; m_addr = m_pc;
    end else if (j || b) begin
      m_pc = t; m_instr = 0; m_valid = 0; m_jflush = 1;
      skid.delete();
      if (m_req && !ack) m_discard = 1;
      else begin m_discard = 0; m_req = 1; m_addr = t; end
    end else begin
      m_jflush = 0;
      if (skid.size() != 0) begin
        if (!s) begin {m_instr, m_pcp4} = skid.pop_front(); m_valid = 1; m_req = 1; end
      end else if (ack && !m_discard) begin
        if (s) begin skid.push_back({data, m_addr + 32'd4}); m_req = 0; end
        else begin m_instr = data; m_pcp4 = m_addr + 32'd4; m_valid = 1; end
        m_addr = m_addr + 32'd4; m_pc = m_pc + 32'd4;
      end else begin
        if (ack) begin m_discard = 0; m_addr = m_pc; end
        if (!s) begin m_instr = 0; m_valid = 0; end
      end
    end
  endtask

  task automatic step(input bit s, input bit j, input logic [31:0] jt, input bit b, input logic [31:0] bt);
    bit ack;
    ack = InstrReq && cnt >= lat;
    Stall = s; Jump = j; JumpTarget = jt; BranchTaken = b; BranchTarget = bt;
    InstrAck = ack;
    InstrData = ack ? mem(InstrAddr) : $urandom;
    m_update(ack, InstrData, s, j, jt, b, bt);
    if (ack || !InstrReq) begin
      cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 2);
    end else cnt++;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    @(negedge Clock);
    vectors++; if (PC !== 0 || InstrAddr !== 0 || InstrReq !== 0) begin miscompares++; $display("FAIL reset_addr: got pc=%h addr=%h req=%b want 0 0 0", PC, InstrAddr, InstrReq); end
    vectors++; if (IFID_Instruction !== 0 || IFID_PCPlus4 !== 0 || IFID_Valid !== 0 || IFID_JFlush !== 0) begin miscompares++; $display("FAIL reset_ifid: got %h %h v=%b f=%b want 0 0 0 0", IFID_Instruction, IFID_PCPlus4, IFID_Valid, IFID_JFlush); end
    Reset = 0; m_reset(); cnt = 0;
    step(0, 0, 0, 0, 0);
    vectors++; if (InstrReq !== 1 || InstrAddr !== 0 || IFID_Valid !== 0) begin miscompares++; $display("FAIL start_req: got req=%b addr=%h v=%b want 1 0 0", InstrReq, InstrAddr, IFID_Valid); end
  endtask

  task automatic test_zero_wait();
    lat = 0;
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_Instruction !== 32'h20080005 || OpCode !== 6'b001000 || InstrAddr !== 32'h4) begin miscompares++; $display("FAIL zw_first: got %h op=%b addr=%h want 20080005 001000 4", IFID_Instruction, OpCode, InstrAddr); end
    vectors++; if (IFID_Valid !== 1 || IFID_PCPlus4 !== 32'h4) begin miscompares++; $display("FAIL zw_valid: got v=%b pcp4=%h want 1 4", IFID_Valid, IFID_PCPlus4); end
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_Instruction !== 32'h01095020 || Funct !== 6'b100000 || InstrAddr !== 32'h8) begin miscompares++; $display("FAIL zw_second: got %h fn=%b addr=%h want 01095020 100000 8", IFID_Instruction, Funct, InstrAddr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      vectors++; if (InstrReq !== 0 || IFID_Instruction !== 32'h01095020 || InstrAddr !== 32'hC) begin miscompares++; $display("FAIL stall_hold%0d: got req=%b ifid=%h addr=%h want 0 01095020 c", i, InstrReq, IFID_Instruction, InstrAddr); end
    end
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_Instruction !== 32'h8C090010 || InstrReq !== 1 || InstrAddr !== 32'hC || IFID_PCPlus4 !== 32'hC) begin miscompares++; $display("FAIL stall_release: got ifid=%h req=%b addr=%h pcp4=%h want 8c090010 1 c c", IFID_Instruction, InstrReq, InstrAddr, IFID_PCPlus4); end
  endtask

  task automatic test_jump_ack();
    step(0, 1, 32'h40, 0, 0);
    vectors++; if (IFID_JFlush !== 1 || IFID_Valid !== 0 || OpCode !== 6'b000000 || InstrAddr !== 32'h40 || PC !== 32'h40) begin miscompares++; $display("FAIL jump_flush: got f=%b v=%b op=%b addr=%h pc=%h want 1 0 0 40 40", IFID_JFlush, IFID_Valid, OpCode, InstrAddr, PC); end
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_JFlush !== 0 || IFID_Valid !== 1 || IFID_PCPlus4 !== 32'h44 || IFID_Instruction !== mem(32'h40)) begin miscompares++; $display("FAIL jump_after: got f=%b v=%b pcp4=%h ifid=%h want 0 1 44 %h", IFID_JFlush, IFID_Valid, IFID_PCPlus4, IFID_Instruction, mem(32'h40)); end
  endtask

  task automatic test_branch_latency();
    lat = 3;
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_Valid !== 0 || InstrAddr !== 32'h44 || InstrReq !== 1) begin miscompares++; $display("FAIL lat_bubble: got v=%b addr=%h req=%b want 0 44 1", IFID_Valid, InstrAddr, InstrReq); end
    step(0, 0, 0, 1, 32'h100);
    vectors++; if (InstrAddr !== 32'h44 || PC !== 32'h100 || IFID_JFlush !== 1) begin miscompares++; $display("FAIL br_pending: got addr=%h pc=%h f=%b want 44 100 1", InstrAddr, PC, IFID_JFlush); end
    step(0, 0, 0, 0, 0);
    vectors++; if (InstrAddr !== 32'h44 || InstrReq !== 1 || IFID_JFlush !== 0 || IFID_Valid !== 0) begin miscompares++; $display("FAIL br_stable: got addr=%h req=%b f=%b v=%b want 44 1 0 0", InstrAddr, InstrReq, IFID_JFlush, IFID_Valid); end
    step(0, 0, 0, 0, 0);
    vectors++; if (InstrAddr !== 32'h100 || IFID_Valid !== 0) begin miscompares++; $display("FAIL br_drop: got addr=%h v=%b want 100 0", InstrAddr, IFID_Valid); end
    for (int i = 0; i < 8 && IFID_Valid !== 1; i++) step(0, 0, 0, 0, 0);
    vectors++; if (IFID_Valid !== 1 || IFID_PCPlus4 !== 32'h104 || IFID_Instruction !== mem(32'h100)) begin miscompares++; $display("FAIL br_target: got v=%b pcp4=%h ifid=%h want 1 104 %h", IFID_Valid, IFID_PCPlus4, IFID_Instruction, mem(32'h100)); end
  endtask

  task automatic test_jump_branch_stall();
    lat = 0;
    step(1, 1, 32'h40, 1, 32'h83);
    vectors++; if (PC !== 32'h80 || InstrAddr !== 32'h80 || IFID_JFlush !== 1 || IFID_Valid !== 0 || IFID_Instruction !== 0) begin miscompares++; $display("FAIL jb_stall: got pc=%h addr=%h f=%b v=%b ifid=%h want 80 80 1 0 0", PC, InstrAddr, IFID_JFlush, IFID_Valid, IFID_Instruction); end
  endtask

  task automatic test_reset_mid();
    lat = 3;
    for (int i = 0; i < 12 && InstrReq !== 0; i++) step(1, 0, 0, 0, 0);
    vectors++; if (InstrReq !== 0 || PC !== 32'h84) begin miscompares++; $display("FAIL hold_reach: got req=%b pc=%h want 0 84", InstrReq, PC); end
    #2 Reset = 1; Stall = 0; InstrAck = 0;
    #1;
    vectors++; if (PC !== 0 || InstrAddr !== 0 || InstrReq !== 0 || IFID_Instruction !== 0 || IFID_PCPlus4 !== 0 || IFID_Valid !== 0 || IFID_JFlush !== 0) begin miscompares++; $display("FAIL async_reset: got pc=%h addr=%h req=%b ifid=%h pcp4=%h v=%b f=%b want all 0", PC, InstrAddr, InstrReq, IFID_Instruction, IFID_PCPlus4, IFID_Valid, IFID_JFlush); end
    @(negedge Clock);
    Reset = 0; m_reset(); cnt = 0; lat = 0;
    step(0, 0, 0, 0, 0);
    vectors++; if (InstrReq !== 1 || InstrAddr !== 0) begin miscompares++; $display("FAIL reset_first_req: got req=%b addr=%h want 1 0", InstrReq, InstrAddr); end
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_Instruction !== 32'h20080005) begin miscompares++; $display("FAIL reset_first_word: got %h want 20080005", IFID_Instruction); end
  endtask

  task automatic test_wrap();
    step(0, 1, 32'hFFFF_FFFE, 0, 0);
    vectors++; if (InstrAddr !== 32'hFFFF_FFFC || PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_target: got addr=%h pc=%h want fffffffc fffffffc", InstrAddr, PC); end
    step(0, 0, 0, 0, 0);
    vectors++; if (IFID_PCPlus4 !== 0 || InstrAddr !== 0 || PC !== 0 || IFID_Valid !== 1) begin miscompares++; $display("FAIL wrap_inc: got pcp4=%h addr=%h pc=%h v=%b want 0 0 0 1", IFID_PCPlus4, InstrAddr, PC, IFID_Valid); end
  endtask

  task automatic test_random();
    logic [31:0] jt, bt;
    logic [159:0] got, exp;
    rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      jt = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFF);
      bt = $urandom & 32'hFFF;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, jt, $urandom_range(0, 12) == 0, bt);
      got = {PC, InstrAddr, IFID_Instruction, IFID_PCPlus4, InstrReq, IFID_Valid, IFID_JFlush, OpCode, Funct, 17'h0};
      exp = {m_pc, m_addr, m_instr, m_pcp4, m_req, m_valid, m_jflush, m_instr[31:26], m_instr[5:0], 17'h0};
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL random_cycle%0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    Reset = 1; Stall = 0; Jump = 0; BranchTaken = 0; InstrAck = 0;
    JumpTarget = 0; BranchTarget = 0; InstrData = 0;
    m_reset();
    test_reset();
    test_zero_wait();
    test_stall();
    test_jump_ack();
    test_branch_latency();
    test_jump_branch_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
